// File: rtl/network_mac_pipe.sv
// Pipelined signed multiply-accumulate with first/last group framing and round/saturate to OUT_WIDTH.
// Latency: NUM_STAGE+1 ce-enabled edges from input to dout/out_valid; one term per ce cycle.
// Backpressure: none; ce=0 freezes every register, outputs included.
module network_mac_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 12,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8,
    parameter int NUM_STAGE = 3,
    parameter int ACC_EN    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic signed [A_WIDTH-1:0]   din0,
    input  logic signed [B_WIDTH-1:0]   din1,
    input  logic                        first,
    input  logic                        last,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        out_valid,
    output logic                        sat
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int ND = NUM_STAGE - 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [ACC_WIDTH:0] RND  = (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RS) : '0;
    localparam logic signed [ACC_WIDTH:0] OMAX = {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OMIN = {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [A_WIDTH-1:0]   a_r;
    logic signed [B_WIDTH-1:0]   b_r;
    logic                        v_r, f_r, l_r;
    logic signed [PW-1:0]        p_dly [ND];
    logic [ND-1:0]               v_dly, f_dly, l_dly;
    logic signed [ACC_WIDTH-1:0] acc;

    logic signed [PW-1:0]        p_d;
    logic                        v_d, f_d, l_d, emit;
    logic signed [ACC_WIDTH-1:0] p_ext, acc_next;
    logic signed [ACC_WIDTH:0]   r_full, r_sh;
    logic signed [OUT_WIDTH-1:0] q_dout;
    logic                        q_sat;

    // Index 0 holds the product; higher indices are the plain delay stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r   <= '0;
            b_r   <= '0;
            v_r   <= 1'b0;
            f_r   <= 1'b0;
            l_r   <= 1'b0;
            v_dly <= '0;
            f_dly <= '0;
            l_dly <= '0;
            for (int i = 0; i < ND; i++) p_dly[i] <= '0;
        end else if (ce) begin
            a_r      <= din0;
            b_r      <= din1;
            v_r      <= in_valid;
            f_r      <= first;
            l_r      <= last;
            p_dly[0] <= PW'(a_r) * PW'(b_r);
            v_dly[0] <= v_r;
            f_dly[0] <= f_r;
            l_dly[0] <= l_r;
            for (int i = 1; i < ND; i++) begin
                p_dly[i] <= p_dly[i-1];
                v_dly[i] <= v_dly[i-1];
                f_dly[i] <= f_dly[i-1];
                l_dly[i] <= l_dly[i-1];
            end
        end
    end

    assign p_d      = p_dly[ND-1];
    assign v_d      = v_dly[ND-1];
    assign f_d      = f_dly[ND-1];
    assign l_d      = l_dly[ND-1];
    assign p_ext    = ACC_WIDTH'(p_d);
    assign acc_next = (f_d || (ACC_EN == 0)) ? p_ext : acc + p_ext;
    assign emit     = v_d && (l_d || (ACC_EN == 0));

    // One extra bit keeps the rounding add from overflowing before the shift.
    assign r_full = (ACC_WIDTH+1)'(acc_next) + RND;
    assign r_sh   = r_full >>> SHIFT;

    always_comb begin
        q_dout = r_sh[OUT_WIDTH-1:0];
        q_sat  = 1'b0;
        if (r_sh > OMAX) begin
            q_dout = OMAX[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end else if (r_sh < OMIN) begin
            q_dout = OMIN[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            dout      <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            if (v_d) acc <= acc_next;
            out_valid <= emit;
            if (emit) begin
                dout <= q_dout;
                sat  <= q_sat;
            end
        end
    end
endmodule

// File: tb/tb_network_mac_pipe.sv
// Directed bench for network_mac_pipe: accumulating, pure-multiplier and deep-pipeline instances share stimulus.
module tb_network_mac_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ce, in_valid, first, last;
    logic signed [15:0] din0;
    logic signed [11:0] din1;
    logic signed [15:0] dout_a, dout_m, dout_5;
    logic ov_a, ov_m, ov_5, sat_a, sat_m, sat_5;

    network_mac_pipe dut_a (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .first(first), .last(last), .dout(dout_a), .out_valid(ov_a), .sat(sat_a));
    network_mac_pipe #(.ACC_EN(0)) dut_m (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .first(first), .last(last), .dout(dout_m), .out_valid(ov_m), .sat(sat_m));
    network_mac_pipe #(.NUM_STAGE(5)) dut_5 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .first(first), .last(last), .dout(dout_5), .out_valid(ov_5), .sat(sat_5));

    typedef struct {
        logic signed [15:0] d;
        logic               s;
        int                 cyc;
    } exp_t;

    exp_t q_a[$], q_m[$], q_5[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic edge_ce = 1'b0;
    logic signed [31:0] acc_m = '0;
    logic signed [15:0] last_a = '0;

    always @(posedge clk) begin
        edge_ce = ce;
        if (ce) cyc++;
    end

    function automatic exp_t mk(input logic signed [31:0] acc, input int c);
        exp_t e;
        longint r;
        r = (longint'(acc) + 128) >>> 8;
        e.s = 1'b1;
        if (r > 32767) e.d = 16'sh7fff;
        else if (r < -32768) e.d = -16'sh8000;
        else begin
            e.d = 16'(r);
            e.s = 1'b0;
        end
        e.cyc = c;
        return e;
    endfunction

    // An output must appear exactly on the edge its expectation is due, and carry the model value.
    `define MON(Q, OV, D, S, TAG) \
        always @(negedge clk) begin \
            exp_t e; \
            logic due; \
            if (edge_ce && reset) begin \
                due = (Q.size() != 0) && (Q[0].cyc == cyc); \
                if (OV || due) begin \
                    checks++; \
                    assert ((OV === 1'b1) && due) else begin \
                        errors++; \
                        $error("FAIL %s timing cyc=%0d out_valid=%b expected_due=%b", TAG, cyc, OV, due); \
                    end \
                    if (due) begin \
                        e = Q.pop_front(); \
                        if (OV) begin \
                            checks++; \
                            assert ((D === e.d) && (S === e.s)) else begin \
                                errors++; \
                                $error("FAIL %s data cyc=%0d got dout=%0d sat=%b want dout=%0d sat=%b", TAG, cyc, D, S, e.d, e.s); \
                            end \
                        end \
                    end \
                end \
            end \
        end

    `MON(q_a, ov_a, dout_a, sat_a, "acc")
    `MON(q_m, ov_m, dout_m, sat_m, "mul")
    `MON(q_5, ov_5, dout_5, sat_5, "ns5")

    task automatic drive(input logic signed [15:0] a, input logic signed [11:0] b,
                         input logic f, input logic l);
        logic signed [31:0] p;
        exp_t e;
        in_valid = 1'b1;
        din0 = a;
        din1 = b;
        first = f;
        last = l;
        @(posedge clk);
        #1;
        p = 32'(a) * 32'(b);
        q_m.push_back(mk(p, cyc + 3));
        acc_m = f ? p : acc_m + p;
        if (l) begin
            e = mk(acc_m, cyc + 3);
            q_a.push_back(e);
            last_a = e.d;
            q_5.push_back(mk(acc_m, cyc + 5));
        end
        in_valid = 1'b0;
        first = 1'b0;
        last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({ov_a, ov_m, ov_5, sat_a, sat_m, sat_5} === 6'b0 &&
                dout_a === 16'sd0 && dout_m === 16'sd0 && dout_5 === 16'sd0) else begin
            errors++;
            $error("FAIL %s got ov=%b%b%b dout=%0d/%0d/%0d want all zero", tag,
                   ov_a, ov_m, ov_5, dout_a, dout_m, dout_5);
        end
    endtask

    initial begin
        reset = 1'b0;
        ce = 1'b1;
        in_valid = 1'b0;
        first = 1'b0;
        last = 1'b0;
        din0 = '0;
        din1 = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b1;
        idle(2);

        // Single multiply; also a single-term group for the accumulating instances.
        drive(1000, 256, 1'b1, 1'b1);
        idle(8);

        // Back-to-back groups: 250 then 1 on consecutive edges.
        drive(100, 256, 1'b1, 1'b0);
        drive(200, 256, 1'b0, 1'b0);
        drive(-50, 256, 1'b0, 1'b1);
        drive(1, 256, 1'b1, 1'b1);
        // Continues the group without a first: acc 256 + 512.
        drive(2, 256, 1'b0, 1'b1);
        idle(8);

        drive(3, 128, 1'b1, 1'b1);
        drive(-3, 128, 1'b1, 1'b1);
        drive(1, 127, 1'b1, 1'b1);
        idle(8);

        drive(32767, 2047, 1'b1, 1'b1);
        drive(-32768, 2047, 1'b1, 1'b1);
        drive(1, 256, 1'b1, 1'b1);
        idle(8);

        // Stall mid-group: outputs must stay frozen at the previous result.
        drive(100, 256, 1'b1, 1'b0);
        drive(200, 256, 1'b0, 1'b0);
        ce = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            assert (ov_a === 1'b0 && dout_a === last_a) else begin
                errors++;
                $error("FAIL stall_frozen got ov=%b dout=%0d want ov=0 dout=%0d", ov_a, dout_a, last_a);
            end
        end
        ce = 1'b1;
        drive(-50, 256, 1'b0, 1'b1);
        idle(10);

        // Reset with a partial group in flight.
        drive(100, 256, 1'b1, 1'b0);
        drive(200, 256, 1'b0, 1'b0);
        reset = 1'b0;
        q_a.delete();
        q_m.delete();
        q_5.delete();
        acc_m = '0;
        last_a = '0;
        repeat (2) begin
            @(negedge clk);
            check_zero("reset_midgroup");
        end
        reset = 1'b1;
        idle(1);
        drive(5, 256, 1'b1, 1'b1);
        idle(12);

        checks++;
        assert (q_a.size() == 0 && q_m.size() == 0 && q_5.size() == 0) else begin
            errors++;
            $error("FAIL drain got pending=%0d/%0d/%0d want 0/0/0", q_a.size(), q_m.size(), q_5.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/network_mac_pipe.md
Name: network_mac_pipe

Overview:
- Parametrised pipelined signed multiply-accumulate unit. Successor to the fixed-width pipelined DSP multiplier used in the conv layers.
- Adds configurable operand, accumulator and output widths; configurable pipeline depth; valid tracking; optional dot-product accumulation framed by first/last flags; round-and-saturate requantisation to OUT_WIDTH.
- Sits between the line-buffer/weight fetch and the activation stage of each conv engine.

Parameters:
- A_WIDTH, 16, signed width of din0 (activation).
- B_WIDTH, 12, signed width of din1 (weight).
- ACC_WIDTH, 32, accumulator width. Must be ≥ A_WIDTH+B_WIDTH. Wraps modulo 2^ACC_WIDTH.
- OUT_WIDTH, 16, signed result width.
- SHIFT, 8, arithmetic right shift applied at requantisation (0..ACC_WIDTH-1).
- NUM_STAGE, 3, multiplier pipeline stages, ≥ 2. End-to-end latency LAT = NUM_STAGE+1 ce-enabled edges.
- ACC_EN, 1. When 1, accumulate over first..last groups. When 0, pure multiplier: every valid input produces an output, first/last ignored.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes every register, outputs included.
- in_valid  in  1  din0/din1/first/last valid this cycle.
- din0  in  A_WIDTH  signed operand a.
- din1  in  B_WIDTH  signed operand b.
- first  in  1  first term of a group (ACC_EN=1).
- last  in  1  last term of a group (ACC_EN=1).
- dout  out  OUT_WIDTH  rounded, saturated result.
- out_valid  out  1  dout valid.
- sat  out  1  dout was clipped; qualified by out_valid.

Behaviour:
- Reset (reset=0, async): all pipeline regs, accumulator, dout, out_valid and sat clear to 0. Partial sums in flight are discarded. First group after release is computed correctly.
- All registers update only on clk edges with ce=1. Each pipeline register is loaded only when ce=1.
- Stage 1: register din0, din1, in_valid, first, last.
- Stage 2: product p = signed(a_r)*signed(b_r), full A_WIDTH+B_WIDTH bits, no truncation.
- Stages 3..NUM_STAGE: NUM_STAGE-2 plain delay registers for p and the flags. None when NUM_STAGE=2.
- Final stage (edge NUM_STAGE+1), when the delayed valid is 1:
  - acc_next = (first_d or ACC_EN=0) ? sext(p) : acc + sext(p), mod 2^ACC_WIDTH.
  - acc <= acc_next.
- Valid without a preceding first accumulates onto the current acc (0 after reset).
- Delayed valid = 0: acc holds.
- Emit when delayed valid=1 and (last_d=1 or ACC_EN=0):
  - r = (acc_next + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. Round half toward +inf, computed in ACC_WIDTH+1 bits so it cannot overflow.
  - dout <= clip(r, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
  - sat <= 1 if clipped, else 0.
  - out_valid <= 1.
- Otherwise, on a ce=1 edge: out_valid <= 0 and dout/sat hold their last value.
- out_valid is a single-ce-edge pulse per group.
- first and last together on one term: a single-term group, result = round/sat(p).
- A first arriving directly after a last (back-to-back groups) needs no bubble. Full throughput is one term per ce cycle.
- ce=0 mid-stream: no state change. Results are delayed by exactly the number of stalled cycles and are bit-identical.

Test Plan:
- Defaults, ACC_EN=0: a=1000, b=256, valid 1 cycle → dout=1000, sat=0, out_valid high exactly 4 edges later for 1 cycle.
- Defaults: group (100,256,first), (200,256), (-50,256,last), back-to-back, then next group (1,256,first+last) immediately → dout=250, then dout=1, on consecutive cycles.
- Rounding: single-term groups a=3,b=128 → dout=2; a=-3,b=128 → dout=-1; a=1,b=127 → dout=0.
- Saturation: a=32767,b=2047 → dout=32767, sat=1; a=-32768,b=2047 → dout=-32768, sat=1; next a=1,b=256 → dout=1, sat=0.
- Stall: 3-term group from scenario 2 with ce=0 for 3 cycles after the second term → out_valid 3 cycles later than unstalled, dout=250. Outputs frozen during the stall.
- Reset mid-group: assert reset after 2 of 3 terms, release, then feed (5,256,first+last) → out_valid/dout=0 during reset, no spurious output, then dout=5. NUM_STAGE=5 rerun → latency 6.
